// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, parity-mode codes and small bit helpers for the UART datapath.
// Latency: none; this file holds only types, constants and combinational functions.
// Backpressure: not applicable.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Parity mode codes; 2'b11 is decoded as "none" by the receiver.
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Smallest data-bit count a frame may carry.
    localparam int DBIT_MIN = 5;

    // Fixed operand width of parity_reduce; callers zero-extend narrower words.
    localparam int PAR_FN_W = 32;

    // XOR-reduce of a zero-extended data word: 1 when it holds an odd number of ones.
    function automatic logic parity_reduce(input logic [PAR_FN_W-1:0] data);
        return ^data;
    endfunction

    // 2-of-3 majority vote.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running oversampling tick generator, one tick every i_dvsr+1 clocks.
// Latency: o_tick is combinational from the counter; a new divisor applies from the next period.
// Backpressure: none; ticks are never stalled.
//
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_dvsr           : divisor; counter runs 0..i_dvsr and ticks at the top count
//   o_tick           : one-clock tick pulse
module uart_baud_gen #(
    parameter int DVSR_W = 11
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [DVSR_W-1:0] i_dvsr,
    output logic              o_tick
);

    logic [DVSR_W-1:0] cnt;
    logic [DVSR_W-1:0] dvsr_q;
    logic [DVSR_W-1:0] lim;

    // The divisor is captured on the first count of every period, so a change
    // made mid-period only alters the period that begins after the next wrap.
    // At count 0 the live input is used directly, which also covers the first
    // period after reset and a divisor of 0 (tick every clock).
    assign lim    = (cnt == '0) ? i_dvsr : dvsr_q;
    assign o_tick = (cnt == lim);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt    <= '0;
            dvsr_q <= '0;
        end else begin
            if (cnt == '0) begin
                dvsr_q <= i_dvsr;
            end
            if (o_tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with runtime frame format (5..DBIT_MAX data bits, none/even/odd parity, 1/2 stop bits).
// Latency: word and flags appear one clock after the last stop-bit sample (2 further clocks of rx synchronizer).
// Backpressure: one-word valid/ready output register; a frame completing while it is stalled is dropped and o_overrun pulses.
//
// Ports:
//   i_clk, i_reset_n      : clock, asynchronous active-low reset
//   i_dvsr                : baud divisor, one oversampling tick every i_dvsr+1 clocks
//   i_dbits               : data bits per frame, clamped to 5..DBIT_MAX
//   i_parity              : 00 none, 01 even, 10 odd, 11 none
//   i_two_stop            : 1 selects two stop bits
//   i_rx                  : asynchronous serial line, idle high
//   o_data                : received word, right-aligned, unused upper bits zero
//   o_valid / i_ready     : output handshake
//   o_parity_err          : parity mismatch, qualified by o_valid
//   o_frame_err           : a stop bit sampled low, qualified by o_valid
//   o_overrun             : one-clock pulse when a completed frame is discarded
//
// Build option: define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote of
// the samples at ticks C-2, C-1 and C around the nominal sample tick C.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DBIT_MAX = 8,
    parameter int SB_TICK  = 16,
    parameter int DVSR_W   = 11
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic [DVSR_W-1:0]             i_dvsr,
    input  logic [$clog2(DBIT_MAX+1)-1:0] i_dbits,
    input  logic [1:0]                    i_parity,
    input  logic                          i_two_stop,
    input  logic                          i_rx,
    output logic [DBIT_MAX-1:0]           o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic                          o_parity_err,
    output logic                          o_frame_err,
    output logic                          o_overrun
);

    localparam int DB_W = $clog2(DBIT_MAX + 1);
    localparam int N_W  = (DBIT_MAX > 1) ? $clog2(DBIT_MAX) : 1;
    localparam int S_W  = $clog2(SB_TICK);

    // Sample points within a bit: mid-start-bit, then one full bit period apart.
    localparam logic [S_W-1:0] S_HALF = S_W'(SB_TICK / 2 - 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(SB_TICK - 1);

    logic                rx_meta;
    logic                rx_sync;
    logic                tick;
    logic                bit_val;

    rx_state_t           state;
    logic [S_W-1:0]      s;
    logic [N_W-1:0]      n;
    logic [N_W-1:0]      dlast_q;
    logic [1:0]          par_q;
    logic                two_stop_q;
    logic                second_stop_q;
    logic [DBIT_MAX-1:0] shreg;
    logic                par_err_q;
    logic                frame_err_q;

    logic [DB_W-1:0]     dbits_eff;
    logic [N_W-1:0]      dlast_next;
    logic                par_en;
    logic                par_err_next;
    logic                frame_err_next;

    // ------------------------------------------------------------------
    // Line synchronizer; flops reset to the idle (high) level.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
        end
    end

    uart_baud_gen #(
        .DVSR_W (DVSR_W)
    ) u_baud_gen (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_dvsr    (i_dvsr),
        .o_tick    (tick)
    );

    // ------------------------------------------------------------------
    // Bit decision value
    // ------------------------------------------------------------------
`ifdef UART_RX_MAJORITY_EN
    logic [S_W-1:0] c_now;
    logic [1:0]     early_q;

    assign c_now = (state == ST_START) ? S_HALF : S_LAST;

    // Capture the two samples preceding the decision tick; the third vote is
    // the live synchronized value at the decision tick itself.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            early_q <= 2'b11;
        end else if (tick) begin
            if (s == c_now - S_W'(2)) begin
                early_q[0] <= rx_sync;
            end
            if (s == c_now - S_W'(1)) begin
                early_q[1] <= rx_sync;
            end
        end
    end

    assign bit_val = maj3(early_q[0], early_q[1], rx_sync);
`else
    assign bit_val = rx_sync;
`endif

    // ------------------------------------------------------------------
    // Frame-format decode
    // ------------------------------------------------------------------
    always_comb begin
        dbits_eff = i_dbits;
        if (i_dbits < DB_W'(DBIT_MIN)) begin
            dbits_eff = DB_W'(DBIT_MIN);
        end else if (i_dbits > DB_W'(DBIT_MAX)) begin
            dbits_eff = DB_W'(DBIT_MAX);
        end
    end

    // The FSM keeps the index of the last data bit rather than the count.
    assign dlast_next = N_W'(dbits_eff - DB_W'(1));

    assign par_en = (par_q == PAR_EVEN) || (par_q == PAR_ODD);

    // Data ones plus the received parity bit must be even (even mode) or odd (odd mode).
    assign par_err_next = (parity_reduce(PAR_FN_W'(shreg)) ^ bit_val) != (par_q == PAR_ODD);

    assign frame_err_next = frame_err_q | ~bit_val;

    // ------------------------------------------------------------------
    // Receive FSM and output register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= ST_IDLE;
            s             <= '0;
            n             <= '0;
            dlast_q       <= '0;
            par_q         <= PAR_NONE;
            two_stop_q    <= 1'b0;
            second_stop_q <= 1'b0;
            shreg         <= '0;
            par_err_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            o_data        <= '0;
            o_valid       <= 1'b0;
            o_parity_err  <= 1'b0;
            o_frame_err   <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!rx_sync) begin
                        state      <= ST_START;
                        s          <= '0;
                        dlast_q    <= dlast_next;
                        par_q      <= i_parity;
                        two_stop_q <= i_two_stop;
                    end
                end

                ST_START: begin
                    if (tick) begin
                        if (s == S_HALF) begin
                            if (!bit_val) begin
                                state         <= ST_DATA;
                                s             <= '0;
                                n             <= '0;
                                shreg         <= '0;
                                par_err_q     <= 1'b0;
                                frame_err_q   <= 1'b0;
                                second_stop_q <= 1'b0;
                            end else begin
                                // Line went back high: treat as a glitch.
                                state <= ST_IDLE;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (tick) begin
                        if (s == S_LAST) begin
                            s        <= '0;
                            shreg[n] <= bit_val;
                            if (n == dlast_q) begin
                                state <= par_en ? ST_PARITY : ST_STOP;
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (tick) begin
                        if (s == S_LAST) begin
                            s         <= '0;
                            par_err_q <= par_err_next;
                            state     <= ST_STOP;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end

                ST_STOP: begin
                    if (tick) begin
                        if (s == S_LAST) begin
                            s <= '0;
                            if (two_stop_q && !second_stop_q) begin
                                second_stop_q <= 1'b1;
                                frame_err_q   <= frame_err_next;
                            end else begin
                                // Return to IDLE at the stop-bit centre so a start
                                // edge arriving right after the stop bit is caught.
                                state <= ST_IDLE;
                                if (!o_valid || i_ready) begin
                                    o_data       <= shreg;
                                    o_parity_err <= par_err_q;
                                    o_frame_err  <= frame_err_next;
                                    o_valid      <= 1'b1;
                                end else begin
                                    o_overrun <= 1'b1;
                                end
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    s     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: self-checking bench for uart_rx_cfg with a serial-line driver and expected-word scoreboard.
// Latency: checks o_valid timing against the start edge for an 8N1 frame at divisor 162.
// Backpressure: exercises i_ready stall, overrun drop and release.
module tb_uart_rx_cfg;

    localparam int DBIT_MAX = 8;
    localparam int SB_TICK  = 16;
    localparam int DVSR_W   = 11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DVSR_W-1:0] dvsr;
    logic [3:0]        dbits;
    logic [1:0]        parity;
    logic              two_stop;
    logic              rx;
    logic [7:0]        o_data;
    logic              o_valid;
    logic              i_ready;
    logic              o_parity_err;
    logic              o_frame_err;
    logic              o_overrun;

    always #5 clk = ~clk;

    uart_rx_cfg #(
        .DBIT_MAX (DBIT_MAX),
        .SB_TICK  (SB_TICK),
        .DVSR_W   (DVSR_W)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_dvsr       (dvsr),
        .i_dbits      (dbits),
        .i_parity     (parity),
        .i_two_stop   (two_stop),
        .i_rx         (rx),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_parity_err (o_parity_err),
        .o_frame_err  (o_frame_err),
        .o_overrun    (o_overrun)
    );

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    typedef struct {
        logic [7:0] tx_data;
        int         tx_bits;
        logic [3:0] cfg_dbits;
        logic [1:0] cfg_par;
        logic       cfg_two;
        logic       send_par;
        logic       par_bit;
        logic       stop1_low;
        logic       stop2_low;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    localparam int NV = 11;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   valid_rises = 0;
    int   overruns = 0;
    int   last_rise_cyc = 0;
    int   t_start = 0;
    logic prev_valid = 1'b0;
    exp_t sb_q[$];
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Output monitor: every accepted word is compared with the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_overrun) overruns++;
            if (o_valid && !prev_valid) begin
                valid_rises++;
                last_rise_cyc = cyc;
            end
            if (o_valid && i_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word", o_data);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("word_data", 32'(o_data), 32'(mon_e.data));
                    chk("word_parity_err", 32'(o_parity_err), 32'(mon_e.perr));
                    chk("word_frame_err", 32'(o_frame_err), 32'(mon_e.ferr));
                end
            end
        end
        prev_valid = o_valid;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1);
    end

    function automatic int bit_clks();
        return SB_TICK * (int'(dvsr) + 1);
    endfunction

    task automatic hold(input logic v, input int clks);
        rx = v;
        repeat (clks) @(posedge clk);
        #1;
    endtask

    task automatic stop_bit(input logic low);
        int b;
        b = bit_clks();
        if (low) begin
            // Low across the sample window, then high so the trailing low
            // is rejected as a glitch rather than taken as a new start.
            hold(1'b0, (b * 3) / 4);
            hold(1'b1, b - (b * 3) / 4);
        end else begin
            hold(1'b1, b);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input int nbits, input logic send_par,
                              input logic par_bit, input logic two, input logic s1_low,
                              input logic s2_low);
        int b;
        b = bit_clks();
        t_start = cyc;
        hold(1'b0, b);
        // Config is latched at the start edge; scrambling it now must not matter.
        dbits    = 4'($urandom_range(0, 15));
        parity   = 2'($urandom_range(0, 3));
        two_stop = 1'($urandom_range(0, 1));
        for (int i = 0; i < nbits; i++) hold(data[i], b);
        if (send_par) hold(par_bit, b);
        stop_bit(s1_low);
        if (two) stop_bit(s2_low);
        hold(1'b1, 2 * b);
    endtask

    task automatic cfg_8n1();
        dbits    = 4'd8;
        parity   = 2'b00;
        two_stop = 1'b0;
    endtask

    initial begin
        vec_t vt[NV];
        int   r0;
        int   ov0;
        int   d;
        int   lo;
        int   hi;
        int   k;

        //          data   bits dbits  par    two   spar  pbit  s1lo  s2lo  exp    perr  ferr
        vt[0]  = '{8'h35, 7, 4'd7,  2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h35, 1'b0, 1'b0};
        vt[1]  = '{8'h35, 7, 4'd7,  2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h35, 1'b1, 1'b0};
        vt[2]  = '{8'h3C, 8, 4'd8,  2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
        vt[3]  = '{8'h5A, 8, 4'd8,  2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0};
        vt[4]  = '{8'h5A, 8, 4'd8,  2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0};
        vt[5]  = '{8'h13, 5, 4'd3,  2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h13, 1'b0, 1'b0};
        vt[6]  = '{8'hE7, 8, 4'd15, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hE7, 1'b0, 1'b0};
        vt[7]  = '{8'h81, 8, 4'd8,  2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0};
        vt[8]  = '{8'h2A, 6, 4'd6,  2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h2A, 1'b0, 1'b0};
        vt[9]  = '{8'h00, 8, 4'd8,  2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[10] = '{8'h1F, 5, 4'd5,  2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1F, 1'b0, 1'b0};

        rx      = 1'b1;
        i_ready = 1'b1;
        dvsr    = 11'd162;
        cfg_8n1();

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_data", 32'(o_data), 32'd0);
        chk("reset_parity_err", 32'(o_parity_err), 32'd0);
        chk("reset_frame_err", 32'(o_frame_err), 32'd0);
        chk("reset_overrun", 32'(o_overrun), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // 8N1 at divisor 162: data plus o_valid timing relative to the start edge.
        // The stop-bit centre is the 152nd tick after start detection (8 + 9*16).
        r0 = valid_rises;
        sb_q.push_back('{8'hA5, 1'b0, 1'b0});
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("8n1_valid_pulses", 32'(valid_rises - r0), 32'd1);
        d  = last_rise_cyc - t_start;
        lo = 151 * (int'(dvsr) + 1) + 3;
        hi = 152 * (int'(dvsr) + 1) + 4;
        checks++;
        if (d < lo || d > hi) begin
            errors++;
            $display("FAIL 8n1_latency: o_valid rose %0d clocks after start edge, expected %0d..%0d", d, lo, hi);
        end

        // Table of frame formats at a faster divisor
        dvsr = 11'd3;
        repeat (2 * bit_clks()) @(posedge clk);
        #1;
        ov0 = overruns;
        for (int i = 0; i < NV; i++) begin
            dbits    = vt[i].cfg_dbits;
            parity   = vt[i].cfg_par;
            two_stop = vt[i].cfg_two;
            sb_q.push_back('{vt[i].exp_data, vt[i].exp_perr, vt[i].exp_ferr});
            send_frame(vt[i].tx_data, vt[i].tx_bits, vt[i].send_par, vt[i].par_bit,
                       vt[i].cfg_two, vt[i].stop1_low, vt[i].stop2_low);
        end
        chk("table_no_overrun", 32'(overruns - ov0), 32'd0);

        // Short low pulse (4 ticks) must be rejected, then a real frame received.
        cfg_8n1();
        r0 = valid_rises;
        hold(1'b0, 4 * (int'(dvsr) + 1));
        hold(1'b1, 2 * bit_clks());
        chk("glitch_no_valid", 32'(valid_rises - r0), 32'd0);
        sb_q.push_back('{8'h5A, 1'b0, 1'b0});
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back frames with the consumer stalled
        i_ready = 1'b0;
        ov0 = overruns;
        cfg_8n1();
        sb_q.push_back('{8'h11, 1'b0, 1'b0});
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cfg_8n1();
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_pulse_count", 32'(overruns - ov0), 32'd1);
        chk("ovr_hold_valid", 32'(o_valid), 32'd1);
        chk("ovr_hold_data", 32'(o_data), 32'h11);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ovr_valid_fall", 32'(o_valid), 32'd0);
        chk("ovr_queue_empty", 32'(sb_q.size()), 32'd0);

        // Reset in the middle of data bit 3, with a stalled word pending
        i_ready = 1'b0;
        cfg_8n1();
        send_frame(8'h77, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_valid", 32'(o_valid), 32'd1);
        cfg_8n1();
        hold(1'b0, bit_clks());
        hold(1'b1, bit_clks());
        hold(1'b1, bit_clks());
        hold(1'b0, bit_clks());
        hold(1'b0, bit_clks() / 2);
        rst_n = 1'b0;
        #1;
        chk("midreset_valid", 32'(o_valid), 32'd0);
        chk("midreset_data", 32'(o_data), 32'd0);
        chk("midreset_parity_err", 32'(o_parity_err), 32'd0);
        chk("midreset_frame_err", 32'(o_frame_err), 32'd0);
        rx = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        i_ready = 1'b1;
        r0 = valid_rises;
        hold(1'b1, 12 * bit_clks());
        chk("midreset_no_partial", 32'(valid_rises - r0), 32'd0);
        cfg_8n1();
        sb_q.push_back('{8'hC3, 1'b0, 1'b0});
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Bounded drain of any expected words still outstanding
        k = 0;
        while (sb_q.size() != 0 && k < 5000) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("final_queue_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
